// File: rtl/histo_uart_rx.sv
// Serial histogram receiver: assembles 8N1 bytes into 24-bit bin counts,
// tags each with its bin number and flags the last bin of a 1024-bin frame.
module histo_uart_rx #(
    parameter int unsigned BAUD_DIV     = 84,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    input  logic        rx_i,
    output logic [23:0] bin_data_o,
    output logic [9:0]  bin_idx_o,
    output logic        bin_vld_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int unsigned TO_W     = (TO_LIMIT < 2) ? 1 : $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            rxPrev_q;
    logic [15:0]     baudCnt_q;
    logic [2:0]      bitCnt_q;
    logic [7:0]      shift_q;
    logic [15:0]     word_q;
    logic [1:0]      byteCnt_q;
    logic [9:0]      binCnt_q;
    logic [TO_W-1:0] toCnt_q;
    logic            stopWait_q;
    logic [23:0]     binData_q;
    logic [9:0]      binIdx_q;
    logic            binVld_q;
    logic            frameDone_q;
    logic            frameErr_q;

    logic startEdge;
    logic halfTick;
    logic bitTick;
    logic toHit;

    assign startEdge = rxPrev_q & ~sync2_q;
    assign halfTick  = (baudCnt_q == 16'(HALF_DIV - 1));
    assign bitTick   = (baudCnt_q == 16'(BAUD_DIV - 1));
    // Fires on the idle cycle that brings the timeout counter to its limit,
    // so a saturated counter cannot pulse frame_err_o a second time.
    assign toHit     = (toCnt_q == TO_W'(TO_LIMIT - 1));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rxPrev_q    <= 1'b1;
            baudCnt_q   <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            byteCnt_q   <= '0;
            binCnt_q    <= '0;
            toCnt_q     <= '0;
            stopWait_q  <= 1'b0;
            binData_q   <= '0;
            binIdx_q    <= '0;
            binVld_q    <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            rxPrev_q    <= sync2_q;
            binVld_q    <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;

            if (!en_i) begin
                state_q    <= IDLE;
                baudCnt_q  <= '0;
                bitCnt_q   <= '0;
                byteCnt_q  <= '0;
                binCnt_q   <= '0;
                toCnt_q    <= '0;
                stopWait_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (startEdge) begin
                            state_q   <= START;
                            baudCnt_q <= '0;
                            toCnt_q   <= '0;
                        end else if (sync2_q) begin
                            if (toCnt_q != TO_W'(TO_LIMIT)) begin
                                toCnt_q <= toCnt_q + TO_W'(1);
                            end
                            if (toHit && (byteCnt_q != 2'd0 || binCnt_q != 10'd0)) begin
                                byteCnt_q  <= '0;
                                binCnt_q   <= '0;
                                frameErr_q <= 1'b1;
                            end
                        end
                    end

                    // Mid-start-bit check rejects short low glitches silently.
                    START: begin
                        if (halfTick) begin
                            baudCnt_q <= '0;
                            bitCnt_q  <= '0;
                            state_q   <= sync2_q ? IDLE : DATA;
                        end else begin
                            baudCnt_q <= baudCnt_q + 16'd1;
                        end
                    end

                    DATA: begin
                        if (bitTick) begin
                            baudCnt_q  <= '0;
                            shift_q    <= {sync2_q, shift_q[7:1]};
                            bitCnt_q   <= bitCnt_q + 3'd1;
                            stopWait_q <= 1'b0;
                            if (bitCnt_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end else begin
                            baudCnt_q <= baudCnt_q + 16'd1;
                        end
                    end

                    STOP: begin
                        if (stopWait_q) begin
                            if (sync2_q) begin
                                stopWait_q <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else if (bitTick) begin
                            baudCnt_q <= '0;
                            if (sync2_q) begin
                                state_q <= IDLE;
                                case (byteCnt_q)
                                    2'd0: begin
                                        word_q[7:0] <= shift_q;
                                        byteCnt_q   <= 2'd1;
                                    end
                                    2'd1: begin
                                        word_q[15:8] <= shift_q;
                                        byteCnt_q    <= 2'd2;
                                    end
                                    default: begin
                                        binData_q   <= {shift_q, word_q};
                                        binIdx_q    <= binCnt_q;
                                        binVld_q    <= 1'b1;
                                        frameDone_q <= (binCnt_q == 10'd1023);
                                        binCnt_q    <= binCnt_q + 10'd1;
                                        byteCnt_q   <= 2'd0;
                                    end
                                endcase
                            end else begin
                                // Bad stop bit: drop the partial word but keep the bin position.
                                frameErr_q <= 1'b1;
                                byteCnt_q  <= '0;
                                stopWait_q <= 1'b1;
                            end
                        end else begin
                            baudCnt_q <= baudCnt_q + 16'd1;
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bin_data_o   = binData_q;
    assign bin_idx_o    = binIdx_q;
    assign bin_vld_o    = binVld_q;
    assign frame_done_o = frameDone_q;
    assign frame_err_o  = frameErr_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/histo_uart_rx.md
HISTO_UART_RX -- requirements
Module: histo_uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 84: clk_i cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32: idle bit-times after which a partial word or frame is abandoned.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port en_i, input, 1: receiver enable.
REQ-006 SHALL have port rx_i, input, 1: asynchronous serial histogram line, idle high.
REQ-007 SHALL have port bin_data_o, output, 24: last assembled bin count.
REQ-008 SHALL have port bin_idx_o, output, 10: bin number of bin_data_o.
REQ-009 SHALL have port bin_vld_o, output, 1: one-cycle strobe, bin_data_o/bin_idx_o new.
REQ-010 SHALL have port frame_done_o, output, 1: one-cycle strobe with the bin 1023 strobe.
REQ-011 SHALL have port frame_err_o, output, 1: one-cycle strobe on framing error or timeout discard.
REQ-012 SHALL have port busy_o, output, 1: high while FSM not in IDLE.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized rx high-to-low transition while en_i=1.
REQ-016 START: wait BAUD_DIV/2 (floor) cycles, resample; low -> DATA, high -> IDLE (glitch, no error, no strobe).
REQ-017 DATA: sample every BAUD_DIV cycles, 8 bits, LSB first; after bit 7 -> STOP.
REQ-018 STOP: sample after BAUD_DIV cycles; high -> byte accepted, -> IDLE; low -> frame_err_o pulse, partial word discarded, wait in STOP until rx high, then -> IDLE.
REQ-019 Word assembly: byte counter 0..2; byte 0 -> bits 7:0, byte 1 -> 15:8, byte 2 -> 23:16.
REQ-020 On byte 2 acceptance: the next cycle bin_data_o loads the 24-bit word, bin_idx_o loads the current bin counter, bin_vld_o=1 for exactly one cycle, byte counter -> 0.
REQ-021 Bin counter SHALL increment after each strobe; strobe at bin 1023 also pulses frame_done_o and wraps the counter to 0.
REQ-022 bin_data_o and bin_idx_o SHALL hold their value between strobes.
REQ-023 Timeout counter SHALL count cycles in IDLE with rx high, clearing on any start bit; at TIMEOUT_BITS*BAUD_DIV cycles, if byte counter != 0 or bin counter != 0: both -> 0 and frame_err_o pulses once; otherwise no action.
REQ-024 Framing error SHALL clear the byte counter only; the bin counter is kept.
REQ-025 Framing error and timeout in the same cycle SHALL produce a single frame_err_o pulse.
REQ-026 en_i=0 SHALL force IDLE and clear byte, bin, and timeout counters the next cycle, with no strobes; bin_data_o/bin_idx_o hold.
REQ-027 en_i deasserted mid-byte SHALL abort that byte silently.

Reset
REQ-028 rstn_i=0 at a clock edge SHALL set FSM=IDLE; byte, bin, and timeout counters=0; synchronizer flops=1.
REQ-029 Reset SHALL set bin_data_o=0, bin_idx_o=0, bin_vld_o=0, frame_done_o=0, frame_err_o=0, busy_o=0.
REQ-030 Reset asserted mid-byte or mid-word SHALL discard all partial data, with no strobe on release.

Verification (BAUD_DIV=8, TIMEOUT_BITS=4)
REQ-031 Bytes 0x56,0x34,0x12 -> one bin_vld_o, bin_data_o=0x123456, bin_idx_o=0, frame_err_o stays 0.
REQ-032 1024 words, word n = n -> 1024 strobes, idx 0..1023 in order, frame_done_o only with idx 1023; next word gets idx 0.
REQ-033 Byte 2 sent with stop bit 0 -> frame_err_o pulse, no bin_vld_o; then a full word -> data correct, idx unchanged.
REQ-034 Two bytes, then 40 idle cycles -> one frame_err_o; next full word arrives with idx 0.
REQ-035 3-cycle low glitch on rx -> no strobes; busy_o returns 0 within 6 cycles.
REQ-036 rstn_i low during bit 4 of byte 1 -> all outputs 0; subsequent full word arrives with idx 0 and correct data.
